// File: rtl/p_beid_interconnect_f0_ahb_code_mem_ctrl.sv
// AHB-Lite slave bridging a single code/data memory (SRAM or ROM) with a
// synchronous one-cycle-latency macro interface, configurable wait states
// and a single-entry exclusive-access monitor.
module p_beid_interconnect_f0_ahb_code_mem_ctrl #(
  parameter int AW          = 16,
  parameter int WAIT_STATES = 1,
  parameter bit WRITE_EN    = 1'b1
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic [2:0]    HBURST,
  input  logic [3:0]    HPROT,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  input  logic          EXREQ,
  output logic [31:0]   HRDATA,
  output logic          HREADYOUT,
  output logic [1:0]    HRESP,
  output logic          EXRESP,
  output logic          MEM_CS,
  output logic          MEM_WE,
  output logic [3:0]    MEM_BE,
  output logic [AW-3:0] MEM_ADDR,
  output logic [31:0]   MEM_WDATA,
  input  logic [31:0]   MEM_RDATA
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_ERR1, S_ERR2} state_t;

  localparam logic [1:0] WS         = 2'(WAIT_STATES);
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  state_t        state_q;
  logic [1:0]    cnt_q;
  logic          mem_cs_q;
  logic          mem_we_q;
  logic [3:0]    mem_be_q;
  logic [AW-3:0] mem_addr_q;
  logic          cap_q;        // MEM_RDATA is valid this cycle
  logic [31:0]   hrdata_q;
  logic          excl_ok_q;    // current write is a successful exclusive
  logic          mon_valid_q;
  logic [AW-3:0] mon_addr_q;

  logic          hready_d;
  logic [3:0]    be_d;
  logic          accept;
  logic          req_err;
  logic          mon_hit;
  logic [AW-3:0] word_addr;

  // Burst type, protection and the SEQ/NONSEQ distinction do not affect this slave.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HPROT, HTRANS[0]};

  assign word_addr = HADDR[AW-1:2];
  assign mon_hit   = mon_valid_q && (mon_addr_q == word_addr);
  assign req_err   = (|HADDR[31:AW]) || (HSIZE > 3'd2) ||
                     ((HSIZE == 3'd1) && HADDR[0]) ||
                     ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00)) ||
                     (HWRITE && (WRITE_EN == 1'b0));

  // Slave ready decoded from the data-phase state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    hready_d = 1'b1;
    case (state_q)
      S_RD:    hready_d = !mem_cs_q && (cnt_q == 2'd0);
      S_WR:    hready_d = (cnt_q == 2'd0);
      S_ERR1:  hready_d = 1'b0;
      default: hready_d = 1'b1;
    endcase
  end

  // Byte-lane enables from transfer size and low address bits.
  always_comb begin
    be_d = 4'b0000;
    case (HSIZE)
      3'd0:    be_d = 4'b0001 << HADDR[1:0];
      3'd1:    be_d = HADDR[1] ? 4'b1100 : 4'b0011;
      default: be_d = 4'b1111;
    endcase
  end

  assign accept    = HSEL && HTRANS[1] && HREADY && hready_d;

  assign HREADYOUT = hready_d;
  assign HRESP     = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? RESP_ERROR : RESP_OKAY;
  assign EXRESP    = (state_q == S_WR) && (cnt_q == 2'd0) && excl_ok_q;
  // With zero wait states the completion cycle is the cycle MEM_RDATA is valid.
  assign HRDATA    = (cap_q && (cnt_q == 2'd0)) ? MEM_RDATA : hrdata_q;
  assign MEM_CS    = mem_cs_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_BE    = mem_be_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = HWDATA;

  // Data-phase FSM, memory strobes, read capture and exclusive monitor.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= '0;
      cap_q       <= 1'b0;
      hrdata_q    <= 32'h0;
      excl_ok_q   <= 1'b0;
      mon_valid_q <= 1'b0;
      mon_addr_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      mem_cs_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_be_q <= 4'b0000;
      cap_q    <= (state_q == S_RD) && mem_cs_q;
      if (cap_q) hrdata_q <= MEM_RDATA;

      case (state_q)
        S_RD: if (!mem_cs_q) begin
          if (cnt_q != 2'd0) cnt_q <= cnt_q - 2'd1;
          else               state_q <= S_IDLE;
        end
        S_WR: begin
          if (cnt_q != 2'd0) cnt_q <= cnt_q - 2'd1;
          else               state_q <= S_IDLE;
        end
        S_ERR1:  state_q <= S_ERR2;
        S_ERR2:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      if (accept) begin
        cnt_q      <= WS;
        excl_ok_q  <= 1'b0;
        mem_addr_q <= word_addr;
        if (req_err) begin
          state_q <= S_ERR1;
        end else if (!HWRITE) begin
          state_q  <= S_RD;
          mem_cs_q <= 1'b1;
          if (EXREQ) begin
            mon_valid_q <= 1'b1;
            mon_addr_q  <= word_addr;
          end
        end else begin
          state_q <= S_WR;
          // A failed exclusive write completes normally but never reaches memory.
          if (!EXREQ || mon_hit) begin
            mem_cs_q <= 1'b1;
            mem_we_q <= 1'b1;
            mem_be_q <= be_d;
          end
          excl_ok_q <= EXREQ && mon_hit;
          if (mon_hit) mon_valid_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_p_beid_interconnect_f0_ahb_code_mem_ctrl.sv
// Scoreboard bench: driver pushes model expectations at acceptance, a
// negedge monitor pops and compares each completed data phase.
module tb_p_beid_interconnect_f0_ahb_code_mem_ctrl;

  localparam int AW = 16;
  localparam int WS = 1;
  localparam int NWORDS = 1 << (AW - 2);

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  logic          HSEL = 1'b0;
  logic [31:0]   HADDR = '0;
  logic [1:0]    HTRANS = 2'b00;
  logic          HWRITE = 1'b0;
  logic [2:0]    HSIZE = 3'd2;
  logic [2:0]    HBURST = '0;
  logic [3:0]    HPROT = '0;
  logic [31:0]   HWDATA = '0;
  logic          EXREQ = 1'b0;
  logic [31:0]   HRDATA;
  logic          HREADYOUT;
  logic [1:0]    HRESP;
  logic          EXRESP, MEM_CS, MEM_WE;
  logic [3:0]    MEM_BE;
  logic [AW-3:0] MEM_ADDR;
  logic [31:0]   MEM_WDATA, MEM_RDATA;

  p_beid_interconnect_f0_ahb_code_mem_ctrl #(.AW(AW), .WAIT_STATES(WS), .WRITE_EN(1'b1)) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADYOUT), .EXREQ(EXREQ), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .EXRESP(EXRESP), .MEM_CS(MEM_CS), .MEM_WE(MEM_WE), .MEM_BE(MEM_BE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA));

  // Read-only instance, zero wait states.
  logic          r_sel = 1'b0, r_write = 1'b0;
  logic [1:0]    r_trans = 2'b00;
  logic [31:0]   r_addr = '0, r_hwdata = '0, r_mem_rdata = 32'h1234_5678;
  logic [31:0]   r_hrdata, unused_rom_wdata;
  logic          r_hreadyout, r_exresp, r_cs, r_we;
  logic [1:0]    r_hresp;
  logic [3:0]    r_be;
  logic [AW-3:0] r_maddr;

  p_beid_interconnect_f0_ahb_code_mem_ctrl #(.AW(AW), .WAIT_STATES(0), .WRITE_EN(1'b0)) u_rom (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(r_sel), .HADDR(r_addr), .HTRANS(r_trans),
    .HWRITE(r_write), .HSIZE(3'd2), .HBURST(3'd0), .HPROT(4'd0), .HWDATA(r_hwdata),
    .HREADY(r_hreadyout), .EXREQ(1'b0), .HRDATA(r_hrdata), .HREADYOUT(r_hreadyout),
    .HRESP(r_hresp), .EXRESP(r_exresp), .MEM_CS(r_cs), .MEM_WE(r_we), .MEM_BE(r_be),
    .MEM_ADDR(r_maddr), .MEM_WDATA(unused_rom_wdata), .MEM_RDATA(r_mem_rdata));

  // Backing memory: synchronous, read data valid the cycle after MEM_CS.
  logic [31:0] mem [NWORDS];
  always @(posedge HCLK) begin
    if (MEM_CS) begin
      if (MEM_WE) begin
        for (int i = 0; i < 4; i++)
          if (MEM_BE[i]) mem[MEM_ADDR][8*i +: 8] <= MEM_WDATA[8*i +: 8];
      end else begin
        MEM_RDATA <= mem[MEM_ADDR];
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          is_rd;
    bit          err;
    logic [31:0] rdata;
    bit          exresp;
    int          lat;
    int          n_cs;
    logic [3:0]  be;
    int          waddr;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ref_mem [NWORDS];
  bit          mon_v = 1'b0;
  int          mon_w = 0;

  function automatic exp_t model(bit wr, bit ex, logic [31:0] a, logic [2:0] sz, logic [31:0] wd);
    exp_t e;
    int   w, nb, lo;
    e = '{default: 0};
    w = int'(a[AW-1:2]);
    e.is_rd = !wr;
    e.waddr = w;
    e.err = (a[31:AW] != 0) || (sz > 2) || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
    if (e.err) begin
      e.lat = 2;
      return e;
    end
    nb = 1 << sz;
    lo = int'(a[1:0]) & ~(nb - 1);
    if (!wr) begin
      e.lat = 2 + WS;
      e.n_cs = 1;
      e.rdata = ref_mem[w];
      if (ex) begin
        mon_v = 1'b1;
        mon_w = w;
      end
    end else begin
      e.lat = 1 + WS;
      if (!ex || (mon_v && mon_w == w)) begin
        e.n_cs = 1;
        e.exresp = ex;
        for (int i = 0; i < nb; i++) begin
          e.be[lo + i] = 1'b1;
          ref_mem[w][8*(lo+i) +: 8] = wd[8*(lo+i) +: 8];
        end
        if (mon_v && mon_w == w) mon_v = 1'b0;
      end
    end
    return e;
  endfunction

  // ---------------- driver ----------------
  task automatic xfer(input bit wr, input bit ex, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd);
    int n = 0;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = a; HSIZE = sz; EXREQ = ex;
    HBURST = 3'($urandom); HPROT = 4'($urandom);
    @(negedge HCLK);
    while (!HREADYOUT && n < 20) begin
      n++;
      @(negedge HCLK);
    end
    if (n >= 20) check("accept_timeout", 32'(HREADYOUT), 32'd1);
    @(posedge HCLK);
    sb_q.push_back(model(wr, ex, a, sz, wd));
    #1;
    if (wr) HWDATA = wd;
    HTRANS = 2'b00;
    HSEL = 1'($urandom);
    EXREQ = 1'b0;
  endtask

  // ---------------- monitor ----------------
  bit          mon_en = 1'b0;
  bit          in_ph = 1'b0;
  int          cyc = 0, cs_cnt = 0;
  logic [3:0]  seen_be = '0;
  logic [AW-3:0] seen_addr = '0;
  logic        seen_we = 1'b0;
  logic [31:0] last_rd = '0;
  int          stray_ex = 0, stray_hold = 0, stray_cs = 0, stray_resp = 0;
  exp_t        me;
  bit          done_rd, done_ex;

  initial forever begin
    @(negedge HCLK);
    if (mon_en) begin
      done_rd = 1'b0;
      done_ex = 1'b0;
      if (in_ph) begin
        cyc++;
        if (MEM_CS) begin
          cs_cnt++;
          seen_be = MEM_BE; seen_addr = MEM_ADDR; seen_we = MEM_WE;
        end
        if (HREADYOUT) begin
          if (sb_q.size() == 0) begin
            check("scoreboard_nonempty", 32'(sb_q.size()), 32'd1);
          end else begin
            me = sb_q.pop_front();
            check("latency", 32'(cyc), 32'(me.lat));
            check("hresp", 32'(HRESP), me.err ? 32'd1 : 32'd0);
            check("exresp", 32'(EXRESP), 32'(me.exresp));
            check("mem_cs_cycles", 32'(cs_cnt), 32'(me.n_cs));
            done_ex = me.exresp;
            if (!me.err && me.is_rd) begin
              check("hrdata", HRDATA, me.rdata);
              last_rd = me.rdata;
              done_rd = 1'b1;
            end
            if (me.n_cs > 0) begin
              check("mem_addr", 32'(seen_addr), 32'(me.waddr));
              check("mem_we", 32'(seen_we), 32'(!me.is_rd));
              if (!me.is_rd) check("mem_be", 32'(seen_be), 32'(me.be));
            end
          end
          in_ph = 1'b0;
        end else if (sb_q.size() > 0) begin
          if (HRESP !== (sb_q[0].err ? 2'b01 : 2'b00)) stray_resp++;
        end
      end else begin
        if (MEM_CS) stray_cs++;
        if (HRESP !== 2'b00) stray_resp++;
      end
      if (EXRESP && !done_ex) stray_ex++;
      if (!done_rd && HRDATA !== last_rd) stray_hold++;
      if (HSEL && HTRANS[1] && HREADYOUT) begin
        in_ph = 1'b1;
        cyc = 0;
        cs_cnt = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] v, a, last_ex_a;
  logic [2:0]  sz;
  bit          wr, ex;
  int          n, cnt;

  initial begin
    for (int i = 0; i < NWORDS; i++) begin
      v = $urandom;
      mem[i] <= v;
      ref_mem[i] = v;
    end
    mem[4] <= 32'hCAFE_F00D;
    ref_mem[4] = 32'hCAFE_F00D;
    last_ex_a = 32'h20;

    // Reset values while held in reset.
    repeat (3) @(negedge HCLK);
    check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("rst_hresp", 32'(HRESP), 32'd0);
    check("rst_exresp", 32'(EXRESP), 32'd0);
    check("rst_hrdata", HRDATA, 32'd0);
    check("rst_mem_cs_we_be", {26'd0, MEM_CS, MEM_WE, MEM_BE}, 32'd0);
    HRESETn = 1'b1;
    mon_en = 1'b1;
    @(posedge HCLK); #1;

    // Directed cases.
    xfer(0, 0, 32'h0000_0010, 3'd2, 32'h0);
    xfer(1, 0, 32'h0000_0003, 3'd0, 32'hAB00_0000);
    xfer(0, 0, 32'h0000_0000, 3'd2, 32'h0);
    xfer(0, 0, 32'h0001_0000, 3'd2, 32'h0);
    xfer(0, 1, 32'h0000_0020, 3'd2, 32'h0);
    xfer(1, 1, 32'h0000_0020, 3'd2, 32'h1111_2222);
    xfer(1, 1, 32'h0000_0020, 3'd2, 32'h3333_4444);
    xfer(0, 0, 32'h0000_0020, 3'd2, 32'h0);
    xfer(0, 1, 32'h0000_0040, 3'd2, 32'h0);
    xfer(1, 0, 32'h0000_0040, 3'd1, 32'h5555_6666);
    xfer(1, 1, 32'h0000_0040, 3'd2, 32'h7777_8888);
    xfer(0, 0, 32'h0000_0040, 3'd2, 32'h0);

    // Randomized traffic over a small window to force hits and RAW.
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge HCLK);
        #1;
      end
      wr = 1'($urandom);
      ex = ($urandom_range(0, 3) == 0);
      sz = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 255));
      if (sz <= 3'd2 && $urandom_range(0, 3) != 0) a = a & ~(32'(1 << sz) - 32'd1);
      if ($urandom_range(0, 19) == 0) a = a | (32'h1 << (16 + $urandom_range(0, 15)));
      if (wr && ex && $urandom_range(0, 1) == 1) begin
        a = last_ex_a;
        sz = 3'd2;
      end
      if (!wr && ex) last_ex_a = a;
      xfer(wr, ex, a, sz, $urandom);
    end

    n = 0;
    while ((sb_q.size() != 0 || in_ph) && n < 30) begin
      @(negedge HCLK);
      n++;
    end
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    check("stray_exresp", 32'(stray_ex), 32'd0);
    check("hrdata_hold", 32'(stray_hold), 32'd0);
    check("stray_mem_cs", 32'(stray_cs), 32'd0);
    check("stray_hresp", 32'(stray_resp), 32'd0);

    // Read-only instance: read completes, write is rejected with two-cycle ERROR.
    @(negedge HCLK);
    r_sel = 1'b1; r_trans = 2'b10; r_write = 1'b0; r_addr = 32'h8;
    @(posedge HCLK); #1;
    r_trans = 2'b00;
    @(negedge HCLK);
    check("rom_rd_wait", 32'(r_hreadyout), 32'd0);
    check("rom_rd_cs", 32'(r_cs), 32'd1);
    check("rom_rd_addr", 32'(r_maddr), 32'd2);
    check("rom_rd_we", 32'(r_we), 32'd0);
    @(negedge HCLK);
    check("rom_rd_ready", 32'(r_hreadyout), 32'd1);
    check("rom_rd_data", r_hrdata, 32'h1234_5678);
    check("rom_rd_resp", 32'(r_hresp), 32'd0);
    r_trans = 2'b10; r_write = 1'b1; r_addr = 32'hC;
    @(posedge HCLK); #1;
    r_trans = 2'b00;
    r_hwdata = 32'hDEAD_BEEF;
    @(negedge HCLK);
    check("rom_wr_err1", {29'd0, r_hreadyout, r_hresp}, 32'h1);
    check("rom_wr_err1_cs", {27'd0, r_cs, r_be}, 32'd0);
    @(negedge HCLK);
    check("rom_wr_err2", {29'd0, r_hreadyout, r_hresp}, 32'h5);
    check("rom_wr_err2_cs", {26'd0, r_cs, r_we, r_be}, 32'd0);
    check("rom_wr_exresp", 32'(r_exresp), 32'd0);
    @(negedge HCLK);
    check("rom_after_err", {29'd0, r_hreadyout, r_hresp}, 32'h4);

    // Asynchronous reset in the middle of a waited read.
    @(posedge HCLK); #1;
    xfer(0, 0, 32'h0000_0010, 3'd2, 32'h0);
    mon_en = 1'b0;
    sb_q.delete();
    in_ph = 1'b0;
    @(negedge HCLK);
    @(negedge HCLK);
    check("pre_reset_in_wait", 32'(HREADYOUT), 32'd0);
    HRESETn = 1'b0;
    #1;
    check("midrst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("midrst_hresp_exresp", {29'd0, HRESP, EXRESP}, 32'd0);
    check("midrst_hrdata", HRDATA, 32'd0);
    check("midrst_mem", {26'd0, MEM_CS, MEM_WE, MEM_BE}, 32'd0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge HCLK);
      if (MEM_CS || MEM_WE) cnt++;
    end
    check("post_reset_no_access", 32'(cnt), 32'd0);
    check("post_reset_ready", 32'(HREADYOUT), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
